// File: rtl/seq_num_tagger_if.sv
// -----------------------------------------------------------------------------
// seq_num_tagger_if
//   Bundles the payload handshake, the tagged-packet handshake, the Ack input
//   and the sequence status outputs of seq_num_tagger.
//
//   master : the surrounding logic (payload source, LCRC sink, Ack receiver).
//   slave  : the seq_num_tagger block itself.
//
//   Signals
//     in_valid / in_ready / in    : TLP payload handshake (PACKET_SIZE bits)
//     out_valid / out_ready / out : tagged packet {4'b0000, seq, payload}
//     ack_valid / ack_seq         : received Ack DLLP and its sequence number
//     next_seq / acked_seq        : NEXT_TRANSMIT_SEQ / ACKD_SEQ
//     outstanding                 : unacknowledged TLP count
//     ack_err                     : only when SEQ_TAG_ACK_ERR_EN is defined
// -----------------------------------------------------------------------------
interface seq_num_tagger_if #(
    parameter int PACKET_SIZE = 32
);
    logic                      in_valid;
    logic                      in_ready;
    logic [PACKET_SIZE-1:0]    in;
    logic                      out_valid;
    logic                      out_ready;
    logic [PACKET_SIZE+16-1:0] out;
    logic                      ack_valid;
    logic [11:0]               ack_seq;
    logic [11:0]               next_seq;
    logic [11:0]               acked_seq;
    logic [11:0]               outstanding;
`ifdef SEQ_TAG_ACK_ERR_EN
    logic                      ack_err;

    modport master (
        output in_valid, in, out_ready, ack_valid, ack_seq,
        input  in_ready, out_valid, out, next_seq, acked_seq, outstanding, ack_err
    );

    modport slave (
        input  in_valid, in, out_ready, ack_valid, ack_seq,
        output in_ready, out_valid, out, next_seq, acked_seq, outstanding, ack_err
    );
`else
    modport master (
        output in_valid, in, out_ready, ack_valid, ack_seq,
        input  in_ready, out_valid, out, next_seq, acked_seq, outstanding
    );

    modport slave (
        input  in_valid, in, out_ready, ack_valid, ack_seq,
        output in_ready, out_valid, out, next_seq, acked_seq, outstanding
    );
`endif
endinterface

// File: rtl/seq_num_tagger.sv
// -----------------------------------------------------------------------------
// seq_num_tagger
//   Transmit-side data link layer stage in front of the LCRC generator.
//   Prepends {4'b0000, seq[11:0]} to each accepted TLP payload and holds the
//   tagged packet in a single output register (full throughput when the
//   downstream keeps out_ready high). Tracks NEXT_TRANSMIT_SEQ, ACKD_SEQ and
//   the outstanding-TLP count, and stalls the source when MAX_OUTSTANDING
//   TLPs are unacknowledged.
//
//   Parameters
//     PACKET_SIZE     : payload width in bits (multiple of 8)
//     MAX_OUTSTANDING : replay window size, 1..2048
//
//   Ports
//     clk   : clock, rising edge
//     reset : synchronous, active-high
//     bus   : seq_num_tagger_if.slave (handshakes, Ack input, status outputs)
//
//   Optional feature macro: SEQ_TAG_ACK_ERR_EN
//     When defined, bus.ack_err pulses for one cycle after an Ack whose
//     sequence distance exceeds the outstanding count was sampled.
// -----------------------------------------------------------------------------
module seq_num_tagger #(
    parameter int PACKET_SIZE     = 32,
    parameter int MAX_OUTSTANDING = 2048
) (
    input logic            clk,
    input logic            reset,
    seq_num_tagger_if.slave bus
);
    localparam int          OUT_W   = PACKET_SIZE + 16;
    localparam logic [11:0] MAX_OUT = 12'(MAX_OUTSTANDING);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [OUT_W-1:0]  out_q, out_d;
    logic [11:0]       next_seq_q, next_seq_d;
    logic [11:0]       acked_seq_q, acked_seq_d;
    logic [11:0]       outstanding_q, outstanding_d;

    logic              blocked;
    logic              in_ready;
    logic              accept;
    logic [11:0]       delta;
    logic              ack_ok;

    // Modulo-4096 distance from the last acknowledged sequence number.
    function automatic logic [11:0] seq_dist(input logic [11:0] to_seq,
                                             input logic [11:0] from_seq);
        return to_seq - from_seq;
    endfunction

    // ---- state register ----
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // ---- next-state logic ----
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (accept) state_d = FULL;
            FULL: begin
                if (accept)             state_d = FULL;
                else if (bus.out_ready) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

    // ---- output logic ----
    // in_ready depends only on registered state, registered outstanding and
    // out_ready; in_valid and ack_valid never feed it.
    always_comb begin
        blocked  = (outstanding_q == MAX_OUT);
        in_ready = !reset && !blocked && ((state_q == EMPTY) || bus.out_ready);
    end

    assign accept = bus.in_valid && in_ready;

    // ---- datapath and sequence bookkeeping ----
    always_comb begin
        out_d       = out_q;
        next_seq_d  = next_seq_q;
        acked_seq_d = acked_seq_q;

        if (accept) begin
            out_d      = {4'b0000, next_seq_q, bus.in};
            next_seq_d = next_seq_q + 12'd1;
        end

        // Window check uses the pre-update count, even when a packet is
        // accepted on the same edge.
        delta  = seq_dist(bus.ack_seq, acked_seq_q);
        ack_ok = bus.ack_valid && (delta != 12'd0) && (delta <= outstanding_q);

        if (ack_ok) begin
            acked_seq_d = bus.ack_seq;
        end

        outstanding_d = outstanding_q + 12'(accept) - (ack_ok ? delta : 12'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q         <= '0;
            next_seq_q    <= 12'd0;
            acked_seq_q   <= 12'hFFF;
            outstanding_q <= 12'd0;
        end else begin
            out_q         <= out_d;
            next_seq_q    <= next_seq_d;
            acked_seq_q   <= acked_seq_d;
            outstanding_q <= outstanding_d;
        end
    end

`ifdef SEQ_TAG_ACK_ERR_EN
    logic ack_err_q, ack_err_d;

    // Out-of-window Ack: flagged for one cycle, otherwise ignored.
    always_comb begin
        ack_err_d = bus.ack_valid && (delta > outstanding_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ack_err_q <= 1'b0;
        end else begin
            ack_err_q <= ack_err_d;
        end
    end

    assign bus.ack_err = ack_err_q;
`endif

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = (state_q == FULL);
    assign bus.out         = out_q;
    assign bus.next_seq    = next_seq_q;
    assign bus.acked_seq   = acked_seq_q;
    assign bus.outstanding = outstanding_q;

endmodule

// File: tb/tb_seq_num_tagger.sv
module tb_seq_num_tagger;
    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    seq_num_tagger_if #(.PACKET_SIZE(32)) bus ();

    seq_num_tagger #(
        .PACKET_SIZE    (32),
        .MAX_OUTSTANDING(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in        = '0;
        bus.out_ready = 1'b0;
        bus.ack_valid = 1'b0;
        bus.ack_seq   = '0;

        // Reset state
        tick();
        tick();
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out", 64'(bus.out), 64'd0);
        chk("rst_next_seq", 64'(bus.next_seq), 64'd0);
        chk("rst_acked_seq", 64'(bus.acked_seq), 64'hFFF);
        chk("rst_outstanding", 64'(bus.outstanding), 64'd0);
`ifdef SEQ_TAG_ACK_ERR_EN
        chk("rst_ack_err", 64'(bus.ack_err), 64'd0);
`endif
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Stream three payloads back to back
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in        = 32'hA0A0A0A0;
        tick();
        chk("s1_out_valid", 64'(bus.out_valid), 64'd1);
        chk("s1_out", 64'(bus.out), 64'h0000_A0A0A0A0);
        bus.in = 32'hB1B1B1B1;
        tick();
        chk("s2_out", 64'(bus.out), 64'h0001_B1B1B1B1);
        bus.in = 32'hC2C2C2C2;
        tick();
        chk("s3_out", 64'(bus.out), 64'h0002_C2C2C2C2);
        bus.in_valid = 1'b0;
        tick();
        chk("s_drain_out_valid", 64'(bus.out_valid), 64'd0);
        chk("s_drain_out_hold", 64'(bus.out), 64'h0002_C2C2C2C2);
        chk("s_next_seq", 64'(bus.next_seq), 64'd3);
        chk("s_outstanding", 64'(bus.outstanding), 64'd3);

        // Ack everything so far: acked 4095 -> 2, delta 3
        bus.ack_valid = 1'b1;
        bus.ack_seq   = 12'd2;
        tick();
        bus.ack_valid = 1'b0;
        chk("a1_acked_seq", 64'(bus.acked_seq), 64'd2);
        chk("a1_outstanding", 64'(bus.outstanding), 64'd0);

        // Backpressure: out_ready low for 5 cycles with in_valid held high
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in        = 32'hD3D3D3D3;
        tick();
        bus.in = 32'hE4E4E4E4;
        chk("bp_first_out", 64'(bus.out), 64'h0003_D3D3D3D3);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_hold_out", 64'(bus.out), 64'h0003_D3D3D3D3);
            chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
            chk("bp_next_seq", 64'(bus.next_seq), 64'd4);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
        tick();
        chk("bp_pass_out", 64'(bus.out), 64'h0004_E4E4E4E4);
        chk("bp_pass_next_seq", 64'(bus.next_seq), 64'd5);
        chk("bp_pass_outstanding", 64'(bus.outstanding), 64'd2);

        // Fill the window (MAX_OUTSTANDING = 4)
        bus.in = 32'hF5F5F5F5;
        tick();
        chk("w1_out", 64'(bus.out), 64'h0005_F5F5F5F5);
        bus.in = 32'h06060606;
        tick();
        chk("w2_out", 64'(bus.out), 64'h0006_06060606);
        chk("w_outstanding", 64'(bus.outstanding), 64'd4);
        chk("w_blocked_in_ready", 64'(bus.in_ready), 64'd0);
        tick();
        chk("w_blocked_out_valid", 64'(bus.out_valid), 64'd0);
        chk("w_blocked_next_seq", 64'(bus.next_seq), 64'd7);
        chk("w_blocked_out_hold", 64'(bus.out), 64'h0006_06060606);
        bus.in_valid  = 1'b0;
        bus.ack_valid = 1'b1;
        bus.ack_seq   = 12'd4;
        #1;
        chk("w_ack_no_comb_path", 64'(bus.in_ready), 64'd0);
        tick();
        bus.ack_valid = 1'b0;
        chk("w_ack_outstanding", 64'(bus.outstanding), 64'd2);
        chk("w_ack_acked_seq", 64'(bus.acked_seq), 64'd4);
        chk("w_ack_in_ready", 64'(bus.in_ready), 64'd1);

        // Ack and accept on the same edge: 3 + 1 - 3 = 1
        bus.in_valid = 1'b1;
        bus.in       = 32'h07070707;
        tick();
        chk("aa_pre_outstanding", 64'(bus.outstanding), 64'd3);
        bus.in        = 32'h08080808;
        bus.ack_valid = 1'b1;
        bus.ack_seq   = 12'd7;
        tick();
        bus.ack_valid = 1'b0;
        bus.in_valid  = 1'b0;
        chk("aa_outstanding", 64'(bus.outstanding), 64'd1);
        chk("aa_acked_seq", 64'(bus.acked_seq), 64'd7);
        chk("aa_next_seq", 64'(bus.next_seq), 64'd9);
        chk("aa_out", 64'(bus.out), 64'h0008_08080808);

        // Reset while a packet is held
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in        = 32'h09090909;
        tick();
        chk("mr_held_valid", 64'(bus.out_valid), 64'd1);
        bus.in_valid = 1'b0;
        reset        = 1'b1;
        tick();
        chk("mr_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mr_out", 64'(bus.out), 64'd0);
        chk("mr_next_seq", 64'(bus.next_seq), 64'd0);
        chk("mr_acked_seq", 64'(bus.acked_seq), 64'hFFF);
        chk("mr_outstanding", 64'(bus.outstanding), 64'd0);
        chk("mr_in_ready", 64'(bus.in_ready), 64'd0);
        reset         = 1'b0;
        bus.out_ready = 1'b1;

        // Two packets, then an out-of-window Ack and a duplicate Ack
        bus.in_valid = 1'b1;
        bus.in       = 32'h11111111;
        tick();
        chk("e1_out", 64'(bus.out), 64'h0000_11111111);
        bus.in = 32'h22222222;
        tick();
        chk("e2_out", 64'(bus.out), 64'h0001_22222222);
        bus.in_valid  = 1'b0;
        bus.ack_valid = 1'b1;
        bus.ack_seq   = 12'd10;
        tick();
        bus.ack_valid = 1'b0;
        chk("bad_ack_acked_seq", 64'(bus.acked_seq), 64'hFFF);
        chk("bad_ack_outstanding", 64'(bus.outstanding), 64'd2);
`ifdef SEQ_TAG_ACK_ERR_EN
        chk("bad_ack_err_high", 64'(bus.ack_err), 64'd1);
`endif
        tick();
`ifdef SEQ_TAG_ACK_ERR_EN
        chk("bad_ack_err_pulse", 64'(bus.ack_err), 64'd0);
`endif
        bus.ack_valid = 1'b1;
        bus.ack_seq   = 12'hFFF;
        tick();
        bus.ack_valid = 1'b0;
        chk("dup_ack_acked_seq", 64'(bus.acked_seq), 64'hFFF);
        chk("dup_ack_outstanding", 64'(bus.outstanding), 64'd2);
`ifdef SEQ_TAG_ACK_ERR_EN
        chk("dup_ack_err", 64'(bus.ack_err), 64'd0);
`endif

        // Run the sequence number up to the wrap, acking the previous packet
        // on every accept so the window never fills.
        for (int nx = 2; nx < 4095; nx++) begin
            bus.in_valid  = 1'b1;
            bus.in        = 32'hAB000000 | 32'(nx);
            bus.ack_valid = 1'b1;
            bus.ack_seq   = 12'(nx - 1);
            tick();
        end
        chk("pl_next_seq", 64'(bus.next_seq), 64'd4095);
        chk("pl_acked_seq", 64'(bus.acked_seq), 64'd4093);
        chk("pl_outstanding", 64'(bus.outstanding), 64'd1);
        chk("pl_out", 64'(bus.out), 64'h0FFE_AB000FFE);
        bus.in      = 32'hCAFE0FFF;
        bus.ack_seq = 12'd4094;
        tick();
        chk("wrap_tag_fff_out", 64'(bus.out), 64'h0FFF_CAFE0FFF);
        chk("wrap_next_seq", 64'(bus.next_seq), 64'd0);
        chk("wrap_acked_seq", 64'(bus.acked_seq), 64'd4094);
        bus.ack_valid = 1'b0;
        bus.in        = 32'hD00D0000;
        tick();
        chk("wrap_tag_000_out", 64'(bus.out), 64'h0000_D00D0000);
        chk("wrap_next_seq_1", 64'(bus.next_seq), 64'd1);
        chk("wrap_outstanding", 64'(bus.outstanding), 64'd2);
        bus.in_valid  = 1'b0;
        bus.ack_valid = 1'b1;
        bus.ack_seq   = 12'd0;
        tick();
        bus.ack_valid = 1'b0;
        chk("wrap_ack_acked_seq", 64'(bus.acked_seq), 64'd0);
        chk("wrap_ack_outstanding", 64'(bus.outstanding), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
